// File: rtl/cl_dram_dma_tnn_sched.sv
// cl_dram_dma_tnn_sched
//
// Image-granular scheduler sharing one TNN stream datapath between NUM_CH
// DMA request channels. One channel is granted per whole input image using
// round-robin arbitration. The granted channel's beats are passed straight
// through to the datapath input FIFO. The channel ID of every in-flight
// image is kept in a small tag FIFO, so that each result can be routed back
// to the channel that submitted it.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   req_bits/vld/rdy   per-channel input beats (channel c at [c*512 +: 512])
//   tnn_in_*           towards the datapath fifo_in
//   tnn_out_*          from the datapath fifo_out
//   rsp_bits/ch/vld/rdy result beats tagged with their originating channel
//   busy               streaming an image, or results still outstanding
//   img_done_cnt       completed results (wraps at 2^32)
//   proto_err          sticky: datapath offered a result with nothing in flight
module cl_dram_dma_tnn_sched #(
  parameter  int unsigned NUM_CH    = 4,
  parameter  int unsigned IMG_BEATS = 64,
  parameter  int unsigned OUT_BEATS = 16,
  parameter  int unsigned TAG_DEPTH = 8,
  localparam int unsigned CW        = $clog2(NUM_CH)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_CH*512-1:0]   req_bits,
  input  logic [NUM_CH-1:0]       req_vld,
  output logic [NUM_CH-1:0]       req_rdy,
  output logic [511:0]            tnn_in_bits,
  output logic                    tnn_in_vld,
  input  logic                    tnn_in_rdy,
  input  logic [511:0]            tnn_out_bits,
  input  logic                    tnn_out_vld,
  output logic                    tnn_out_rdy,
  output logic [511:0]            rsp_bits,
  output logic [CW-1:0]           rsp_ch,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic                    busy,
  output logic [31:0]             img_done_cnt,
  output logic                    proto_err
);

  localparam int unsigned BW = $clog2(IMG_BEATS + 1);
  localparam int unsigned OW = $clog2(OUT_BEATS + 1);
  localparam int unsigned AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned PW = $clog2(TAG_DEPTH) + 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(IMG_BEATS - 1);
  localparam logic [OW-1:0] LAST_OUT  = OW'(OUT_BEATS - 1);
  localparam logic [PW-1:0] OCC_FULL  = PW'(TAG_DEPTH);
  localparam logic [AW-1:0] PTR_LAST  = AW'(TAG_DEPTH - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic [PW-1:0]   occ_q, occ_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     img_done_q, img_done_d;
  logic            proto_err_q, proto_err_d;
  logic [CW-1:0]   tag_mem_q [TAG_DEPTH];

  logic [511:0]    ch_bits [NUM_CH];
  logic [CW-1:0]   cand;
  logic [CW-1:0]   win_ch;
  logic            win_found;
  logic            tag_ne;
  logic            tag_full;
  logic            push;
  logic            pop;
  logic            out_hs;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_bits[g] = req_bits[g*512 +: 512];
  end

  assign tag_ne   = (occ_q != '0);
  assign tag_full = (occ_q == OCC_FULL);

  // Round-robin search starting at rr_ptr and wrapping; first requester wins.
  always_comb begin
    cand      = '0;
    win_ch    = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CW'((32'(rr_ptr_q) + i) % NUM_CH);
      if (!win_found && req_vld[cand]) begin
        win_found = 1'b1;
        win_ch    = cand;
      end
    end
  end

  // Input-side FSM: arbitrate in IDLE, pass the locked channel through in STREAM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    push        = 1'b0;
    tnn_in_bits = '0;
    tnn_in_vld  = 1'b0;
    req_rdy     = '0;
    unique case (state_q)
      S_IDLE: begin
        // Full is judged on the pre-pop occupancy, so a pop in this cycle
        // does not open a slot for a grant in the same cycle.
        if (win_found && !tag_full) begin
          gnt_d      = win_ch;
          rr_ptr_d   = (win_ch == CH_LAST) ? '0 : win_ch + CW'(1);
          beat_cnt_d = '0;
          push       = 1'b1;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        tnn_in_bits    = ch_bits[gnt_q];
        tnn_in_vld     = req_vld[gnt_q];
        req_rdy[gnt_q] = tnn_in_rdy;
        if (req_vld[gnt_q] && tnn_in_rdy) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output path: results are only let through while an image is in flight.
  always_comb begin
    rsp_vld     = tag_ne & tnn_out_vld;
    tnn_out_rdy = tag_ne & rsp_rdy;
    rsp_bits    = tag_ne ? tnn_out_bits : '0;
    rsp_ch      = tag_ne ? tag_mem_q[rd_ptr_q] : '0;
    out_hs      = rsp_vld & rsp_rdy;
    pop         = out_hs && (out_cnt_q == LAST_OUT);
  end

  always_comb begin
    out_cnt_d   = out_cnt_q;
    img_done_d  = img_done_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    proto_err_d = proto_err_q | (tnn_out_vld & ~tag_ne);
    if (out_hs) begin
      out_cnt_d = out_cnt_q + OW'(1);
    end
    if (pop) begin
      out_cnt_d  = '0;
      img_done_d = img_done_q + 32'd1;
      rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + PW'(1);
      2'b01:   occ_d = occ_q - PW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_cnt_q   <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      img_done_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_cnt_q   <= out_cnt_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      img_done_q  <= img_done_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while occupancy is non-zero.
  always_ff @(posedge aclk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= win_ch;
    end
  end

  assign busy         = (state_q == S_STREAM) | tag_ne;
  assign img_done_cnt = img_done_q;
  assign proto_err    = proto_err_q;

endmodule
